// File: rtl/exec_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : exec_ctrl_pkg                                          |
// | Description : Shared types and default widths for the run-control    |
// |               sequencer (state encoding, default parameter values).  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package exec_ctrl_pkg;

  localparam int c_ADDR_W_DFLT = 9;
  localparam int c_CNT_W_DFLT  = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_HALTED    = 3'd4
  } exec_state_t;

  // States in which the core is executing a program (cycles are billed).
  function automatic logic is_active(input exec_state_t st);
    return (st == ST_RUN) || (st == ST_STEP_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/exec_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sat_counter                                            |
// | Description : W-bit up-counter with synchronous clear that holds at  |
// |               all-ones; sat_pulse flags an increment that reaches    |
// |               (or pushes against) the maximum value.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat_pulse
);

  localparam logic [W-1:0] c_MAX = '1;

  logic [W-1:0] r_count;

  assign count     = r_count;
  assign sat_pulse = inc & ~clr & (r_count >= c_MAX - 1'b1);

  // Count up on inc, clear has priority, never wrap past all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != c_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/exec_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : exec_ctrl                                              |
// | Description : Run-control sequencer for the single-cycle core:       |
// |               start / PC load / run / single-step / halt, core       |
// |               enable gating and saturating performance counters.     |
// |               Optional watchdog enabled by EXEC_CTRL_WATCHDOG_EN.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W_DFLT,
  parameter int CNT_W  = c_CNT_W_DFLT
`ifdef EXEC_CTRL_WATCHDOG_EN
  , parameter int WDOG_W = 20
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic              halt_in,
  input  logic              branch_taken_in,
  output logic              core_en,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  taken_count,
  output logic              cnt_sat
`ifdef EXEC_CTRL_WATCHDOG_EN
  , input  logic [WDOG_W-1:0] wdog_limit,
  output logic                wdog_trip
`endif
);

  exec_state_t       r_state;
  logic              r_step_prev;
  logic              r_done;
  logic              r_cnt_sat;
  logic [ADDR_W-1:0] r_pc_load_addr;

  logic w_active;
  logic w_step_edge;
  logic w_core_en;
  logic w_commit;
  logic w_halt;
  logic w_wdog_hit;
  logic w_sat_instr;
  logic w_sat_cycle;
  logic w_sat_taken;

  assign w_active    = is_active(r_state);
  assign w_step_edge = step_req & ~r_step_prev;
  // In step mode only a fresh rising edge of step_req releases an instruction.
  assign w_core_en   = (r_state == ST_RUN) | ((r_state == ST_STEP_WAIT) & w_step_edge);
  // halt_in / branch_taken_in are meaningful only when the instruction commits.
  assign w_commit    = w_core_en & ~halt_in;
  assign w_halt      = w_core_en & halt_in;

  assign core_en      = w_core_en;
  assign pc_load      = (r_state == ST_LOAD);
  assign pc_load_addr = r_pc_load_addr;
  assign done         = r_done;
  assign busy         = (r_state == ST_LOAD) | w_active;
  assign cnt_sat      = r_cnt_sat;

`ifdef EXEC_CTRL_WATCHDOG_EN
  logic [WDOG_W-1:0] w_wdog_cnt;
  logic              w_wdog_sat;
  logic              r_wdog_trip;

  sat_counter #(.W(WDOG_W)) u_wdog_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start),
    .inc       (w_active),
    .count     (w_wdog_cnt),
    .sat_pulse (w_wdog_sat)
  );

  // The limit-th active cycle is the last one; a saturated count is a backstop.
  assign w_wdog_hit = w_active && (wdog_limit != '0) &&
                      ((w_wdog_cnt >= wdog_limit - 1'b1) || w_wdog_sat);
  assign wdog_trip  = r_wdog_trip;

  // Sticky trip flag, cleared when a new run is started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_trip <= 1'b0;
    end else if (start) begin
      r_wdog_trip <= 1'b0;
    end else if (w_wdog_hit) begin
      r_wdog_trip <= 1'b1;
    end
  end
`else
  assign w_wdog_hit = 1'b0;
`endif

  // Run-control FSM; start overrides everything, including a halt in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_done         <= 1'b0;
      r_pc_load_addr <= '0;
    end else if (start) begin
      r_state        <= ST_LOAD;
      r_done         <= 1'b0;
      r_pc_load_addr <= start_addr;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_IDLE;
        ST_LOAD: r_state <= step_mode ? ST_STEP_WAIT : ST_RUN;
        ST_RUN: begin
          if (w_halt || w_wdog_hit) begin
            r_state <= ST_HALTED;
            r_done  <= 1'b1;
          end else if (step_mode) begin
            r_state <= ST_STEP_WAIT;
          end
        end
        ST_STEP_WAIT: begin
          if (w_halt || w_wdog_hit) begin
            r_state <= ST_HALTED;
            r_done  <= 1'b1;
          end else if (!step_mode) begin
            r_state <= ST_RUN;
          end
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Previous step_req value for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_prev <= 1'b0;
    end else begin
      r_step_prev <= step_req;
    end
  end

  // Sticky saturation flag across all performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_sat <= 1'b0;
    end else if (start) begin
      r_cnt_sat <= 1'b0;
    end else if (w_sat_instr || w_sat_cycle || w_sat_taken) begin
      r_cnt_sat <= 1'b1;
    end
  end

  // Counters clear on the edge that enters LOAD so they read zero during LOAD.
  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start),
    .inc       (w_commit),
    .count     (instr_count),
    .sat_pulse (w_sat_instr)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start),
    .inc       (w_active),
    .count     (cycle_count),
    .sat_pulse (w_sat_cycle)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start),
    .inc       (w_commit & branch_taken_in),
    .count     (taken_count),
    .sat_pulse (w_sat_taken)
  );

endmodule
`default_nettype wire
